// File: rtl/pipe_sequencer_if.sv
// Decoder <-> sequencer bundle: decoded instruction in, issue/hazard/PC-select controls out.
// Handshake: the decoder holds dec_* stable while dec_valid=1; the instruction is consumed
// on a cycle with issue=1 and must be held unchanged while stall=1.
interface pipe_sequencer_if;
   logic        dec_valid;
   logic [4:0]  dec_op;
   logic [3:0]  dec_rd;
   logic [3:0]  dec_rs;
   logic [3:0]  dec_rt;
   logic [3:0]  dec_rdsrc;
   logic        dec_use_s;
   logic        dec_use_t;
   logic        dec_use_d;
   logic [15:0] dec_pc;
   logic        br_false;
   logic        issue;
   logic        stall;
   logic        flush;
   logic [1:0]  pc_sel;
   logic [15:0] ret_addr;
   logic [1:0]  fwd_s;
   logic [1:0]  fwd_t;
   logic [1:0]  fwd_d;
   logic        halt;
   logic        cs_ovf;
   logic [1:0]  dbg_state;

   modport master (
      output dec_valid, dec_op, dec_rd, dec_rs, dec_rt, dec_rdsrc,
             dec_use_s, dec_use_t, dec_use_d, dec_pc, br_false,
      input  issue, stall, flush, pc_sel, ret_addr, fwd_s, fwd_t, fwd_d,
             halt, cs_ovf, dbg_state
   );

   modport slave (
      input  dec_valid, dec_op, dec_rd, dec_rs, dec_rt, dec_rdsrc,
             dec_use_s, dec_use_t, dec_use_d, dec_pc, br_false,
      output issue, stall, flush, pc_sel, ret_addr, fwd_s, fwd_t, fwd_d,
             halt, cs_ovf, dbg_state
   );
endinterface

// File: rtl/pipe_sequencer.sv
// Issue/hazard controller: scoreboard, forwarding selects, call stack, trap drain FSM.
// Optional feature macro: PIPE_FWD_EN (operand forwarding; without it every hazard stalls).
module pipe_sequencer #(
   parameter int DEPTH = 4
) (
   input logic              i_clk,
   input logic              i_reset,
   pipe_sequencer_if.slave  bus_if
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   localparam logic [4:0] OP_LOAD  = 5'h08;
   localparam logic [4:0] OP_JUMP  = 5'h10;
   localparam logic [4:0] OP_JUMPF = 5'h11;
   localparam logic [4:0] OP_CALL  = 5'h12;
   localparam logic [4:0] OP_RET   = 5'h13;
   localparam logic [4:0] OP_TRAP  = 5'h14;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   state_t r_state;
   state_t w_next;

   // Scoreboard: X = stage 2, M = writeback pending. M never needs is_load.
   logic       r_x_v;
   logic [3:0] r_x_rd;
   logic       r_m_v;
   logic [3:0] r_m_rd;

   logic [15:0]   r_stack [DEPTH];
   logic [PW-1:0] r_sp;
   logic [CW-1:0] r_cnt;
   logic          r_ovf;

   logic        w_issue;
   logic        w_stall;
   logic        w_flush;
   logic [1:0]  w_pc_sel;
   logic        w_push;
   logic        w_pop;
   logic        w_hz_stall;
   logic [1:0]  w_fwd_s;
   logic [1:0]  w_fwd_t;
   logic [1:0]  w_fwd_d;
   logic [PW-1:0] w_sp_inc;

   function automatic logic f_hit(input logic use_src, input logic [3:0] src,
                                  input logic slot_v, input logic [3:0] slot_rd);
      return use_src && (src != 4'd0) && slot_v && (slot_rd == src);
   endfunction

   logic w_hx_s, w_hx_t, w_hx_d, w_hm_s, w_hm_t, w_hm_d;
   assign w_hx_s = f_hit(bus_if.dec_use_s, bus_if.dec_rs,    r_x_v, r_x_rd);
   assign w_hx_t = f_hit(bus_if.dec_use_t, bus_if.dec_rt,    r_x_v, r_x_rd);
   assign w_hx_d = f_hit(bus_if.dec_use_d, bus_if.dec_rdsrc, r_x_v, r_x_rd);
   assign w_hm_s = f_hit(bus_if.dec_use_s, bus_if.dec_rs,    r_m_v, r_m_rd);
   assign w_hm_t = f_hit(bus_if.dec_use_t, bus_if.dec_rt,    r_m_v, r_m_rd);
   assign w_hm_d = f_hit(bus_if.dec_use_d, bus_if.dec_rdsrc, r_m_v, r_m_rd);

`ifdef PIPE_FWD_EN
   // Only a load result is unavailable from X; one stall moves it into M.
   logic r_x_ld;
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) r_x_ld <= 1'b0;
      else          r_x_ld <= w_issue && (bus_if.dec_op == OP_LOAD);
   end
   assign w_hz_stall = r_x_ld && (w_hx_s || w_hx_t || w_hx_d);
   assign w_fwd_s = !w_issue ? 2'd0 : w_hx_s ? 2'd1 : w_hm_s ? 2'd2 : 2'd0;
   assign w_fwd_t = !w_issue ? 2'd0 : w_hx_t ? 2'd1 : w_hm_t ? 2'd2 : 2'd0;
   assign w_fwd_d = !w_issue ? 2'd0 : w_hx_d ? 2'd1 : w_hm_d ? 2'd2 : 2'd0;
`else
   assign w_hz_stall = w_hx_s || w_hx_t || w_hx_d || w_hm_s || w_hm_t || w_hm_d;
   assign w_fwd_s = 2'd0;
   assign w_fwd_t = 2'd0;
   assign w_fwd_d = 2'd0;
`endif

   always_comb begin
      w_next   = r_state;
      w_stall  = 1'b0;
      w_issue  = 1'b0;
      w_flush  = 1'b0;
      w_pc_sel = 2'd0;
      w_push   = 1'b0;
      w_pop    = 1'b0;
      case (r_state)
         ST_RUN: begin
            w_stall = bus_if.dec_valid && w_hz_stall;
            w_issue = bus_if.dec_valid && !w_stall;
            if (w_stall) begin
               w_pc_sel = 2'd3;
            end else if (w_issue) begin
               case (bus_if.dec_op)
                  OP_JUMP: begin
                     w_pc_sel = 2'd1;
                     w_flush  = 1'b1;
                  end
                  OP_JUMPF: begin
                     if (bus_if.br_false) begin
                        w_pc_sel = 2'd1;
                        w_flush  = 1'b1;
                     end
                  end
                  OP_CALL: begin
                     w_push   = 1'b1;
                     w_pc_sel = 2'd1;
                     w_flush  = 1'b1;
                  end
                  OP_RET: begin
                     w_pop    = 1'b1;
                     w_pc_sel = 2'd2;
                     w_flush  = 1'b1;
                  end
                  OP_TRAP: w_next = ST_DRAIN;
                  default: ;
               endcase
            end
         end
         ST_DRAIN: begin
            w_stall  = 1'b1;
            w_pc_sel = 2'd3;
            // M takes X at this edge and X takes a bubble, so an empty X means both drain now.
            if (!r_x_v) w_next = ST_HALT;
         end
         ST_HALT: begin
            w_stall  = 1'b1;
            w_pc_sel = 2'd3;
         end
         default: w_next = ST_RUN;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state <= ST_RUN;
         r_x_v   <= 1'b0;
         r_x_rd  <= 4'd0;
         r_m_v   <= 1'b0;
         r_m_rd  <= 4'd0;
      end else begin
         r_state <= w_next;
         r_m_v   <= r_x_v;
         r_m_rd  <= r_x_rd;
         r_x_v   <= w_issue;
         r_x_rd  <= w_issue ? bus_if.dec_rd : 4'd0;
      end
   end

   assign w_sp_inc = r_sp + 1'b1;

   // Circular stack: a push when full overwrites the oldest slot.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_sp  <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else if (w_push) begin
         r_sp <= w_sp_inc;
         if (r_cnt == CW'(DEPTH)) r_ovf <= 1'b1;
         else                     r_cnt <= r_cnt + 1'b1;
      end else if (w_pop && (r_cnt != '0)) begin
         r_sp  <= r_sp - 1'b1;
         r_cnt <= r_cnt - 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_stack[w_sp_inc] <= bus_if.dec_pc + 16'd1;
   end

   assign bus_if.issue     = w_issue;
   assign bus_if.stall     = w_stall;
   assign bus_if.flush     = w_flush;
   assign bus_if.pc_sel    = w_pc_sel;
   assign bus_if.ret_addr  = (r_cnt != '0) ? r_stack[r_sp] : 16'h0000;
   assign bus_if.fwd_s     = w_fwd_s;
   assign bus_if.fwd_t     = w_fwd_t;
   assign bus_if.fwd_d     = w_fwd_d;
   assign bus_if.halt      = (r_state == ST_HALT);
   assign bus_if.cs_ovf    = r_ovf;
   assign bus_if.dbg_state = r_state;
endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed bench for pipe_sequencer; expectations follow the PIPE_FWD_EN setting of the build.
module tb_pipe_sequencer;
   localparam logic [4:0] OP_ADD   = 5'h00;
   localparam logic [4:0] OP_LOAD  = 5'h08;
   localparam logic [4:0] OP_JUMP  = 5'h10;
   localparam logic [4:0] OP_JUMPF = 5'h11;
   localparam logic [4:0] OP_CALL  = 5'h12;
   localparam logic [4:0] OP_RET   = 5'h13;
   localparam logic [4:0] OP_TRAP  = 5'h14;
   localparam logic [4:0] OP_NOP   = 5'h1F;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int n_checks = 0;
   int n_fail = 0;
   logic [12:0] exp_c;
   logic [15:0] exp_ra;
   logic        exp_ovf;
   logic [15:0] exp_q[$];
   logic [12:0] obs;

   pipe_sequencer_if bus_if();

   pipe_sequencer #(.DEPTH(4)) dut (
      .i_clk   (clk),
      .i_reset (reset),
      .bus_if  (bus_if)
   );

   always #5 clk = ~clk;

   assign obs = {bus_if.issue, bus_if.stall, bus_if.flush, bus_if.pc_sel,
                 bus_if.fwd_s, bus_if.fwd_t, bus_if.fwd_d, bus_if.halt, bus_if.cs_ovf};

   // {issue, stall, flush, pc_sel, fwd_s, fwd_t, fwd_d, halt, cs_ovf}
   function automatic logic [12:0] ctl(input int is, st, fl, ps, fs, ft, fd, hl, ov);
      return {is[0], st[0], fl[0], ps[1:0], fs[1:0], ft[1:0], fd[1:0], hl[0], ov[0]};
   endfunction

   task automatic set_idle();
      bus_if.dec_valid = 1'b0;
      bus_if.dec_op    = OP_NOP;
      bus_if.dec_rd    = 4'd0;
      bus_if.dec_rs    = 4'd0;
      bus_if.dec_rt    = 4'd0;
      bus_if.dec_rdsrc = 4'd0;
      bus_if.dec_use_s = 1'b0;
      bus_if.dec_use_t = 1'b0;
      bus_if.dec_use_d = 1'b0;
      bus_if.dec_pc    = 16'h0000;
      bus_if.br_false  = 1'b0;
   endtask

   task automatic set_instr(input logic [4:0] op, input logic [3:0] rd, rs, rt, rdsrc,
                            input logic us, ut, ud, input logic [15:0] pc);
      bus_if.dec_valid = 1'b1;
      bus_if.dec_op    = op;
      bus_if.dec_rd    = rd;
      bus_if.dec_rs    = rs;
      bus_if.dec_rt    = rt;
      bus_if.dec_rdsrc = rdsrc;
      bus_if.dec_use_s = us;
      bus_if.dec_use_t = ut;
      bus_if.dec_use_d = ud;
      bus_if.dec_pc    = pc;
      bus_if.br_false  = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycles(input int n);
      set_idle();
      repeat (n) step();
   endtask

   task automatic test_reset();
      set_idle();
      repeat (2) @(posedge clk);
      @(negedge clk);
      exp_c = ctl(0,0,0,0,0,0,0,0,0); n_checks++;
      if (obs !== exp_c) begin n_fail++; $display("FAIL reset_ctl: got %b want %b", obs, exp_c); end
      n_checks++;
      if (bus_if.ret_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_ret_addr: got %h want 0000", bus_if.ret_addr); end
      n_checks++;
      if (bus_if.dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", bus_if.dbg_state); end
      step();
      reset = 1'b1;
      @(negedge clk);
      n_checks++;
      if (obs !== exp_c) begin n_fail++; $display("FAIL post_reset_idle: got %b want %b", obs, exp_c); end
      step();
   endtask

   task automatic test_alu_hazard();
      set_instr(OP_ADD, 4'd1, 4'd2, 4'd3, 4'd0, 1'b1, 1'b1, 1'b0, 16'h0010);
      @(negedge clk);
      exp_c = ctl(1,0,0,0,0,0,0,0,0); n_checks++;
      if (obs !== exp_c) begin n_fail++; $display("FAIL alu_producer: got %b want %b", obs, exp_c); end
      step();
      set_instr(OP_ADD, 4'd4, 4'd1, 4'd1, 4'd0, 1'b1, 1'b1, 1'b0, 16'h0011);
`ifdef PIPE_FWD_EN
      @(negedge clk);
      exp_c = ctl(1,0,0,0,1,1,0,0,0); n_checks++;
      if (obs !== exp_c) begin n_fail++; $display("FAIL alu_fwd_x: got %b want %b", obs, exp_c); end
      step();
`else
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         exp_c = ctl(0,1,0,3,0,0,0,0,0); n_checks++;
         if (obs !== exp_c) begin n_fail++; $display("FAIL alu_stall_%0d: got %b want %b", i, obs, exp_c); end
         step();
      end
      @(negedge clk);
      exp_c = ctl(1,0,0,0,0,0,0,0,0); n_checks++;
      if (obs !== exp_c) begin n_fail++; $display("FAIL alu_issue_after_stall: got %b want %b", obs, exp_c); end
      step();
`endif
      set_idle();
      @(negedge clk);
      exp_c = ctl(0,0,0,0,0,0,0,0,0); n_checks++;
      if (obs !== exp_c) begin n_fail++; $display("FAIL alu_idle: got %b want %b", obs, exp_c); end
      idle_cycles(2);
   endtask

   task automatic test_m_hazard();
      set_instr(OP_ADD, 4'd7, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0020);
      step();
      set_instr(OP_ADD, 4'd8, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0021);
      step();
      set_instr(OP_ADD, 4'd9, 4'd7, 4'd8, 4'd0, 1'b1, 1'b1, 1'b0, 16'h0022);
`ifdef PIPE_FWD_EN
      @(negedge clk);
      exp_c = ctl(1,0,0,0,2,1,0,0,0); n_checks++;
      if (obs !== exp_c) begin n_fail++; $display("FAIL m_fwd_mixed: got %b want %b", obs, exp_c); end
      step();
`else
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         exp_c = ctl(0,1,0,3,0,0,0,0,0); n_checks++;
         if (obs !== exp_c) begin n_fail++; $display("FAIL m_stall_%0d: got %b want %b", i, obs, exp_c); end
         step();
      end
      @(negedge clk);
      exp_c = ctl(1,0,0,0,0,0,0,0,0); n_checks++;
      if (obs !== exp_c) begin n_fail++; $display("FAIL m_issue_after_stall: got %b want %b", obs, exp_c); end
      step();
`endif
      idle_cycles(2);
   endtask

   task automatic test_r0_source();
      set_instr(OP_ADD, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0030);
      step();
      set_instr(OP_ADD, 4'd5, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 16'h0031);
      @(negedge clk);
      exp_c = ctl(1,0,0,0,0,0,0,0,0); n_checks++;
      if (obs !== exp_c) begin n_fail++; $display("FAIL r0_no_hazard: got %b want %b", obs, exp_c); end
      step();
      idle_cycles(2);
   endtask

   task automatic test_load_use();
      set_instr(OP_LOAD, 4'd5, 4'd2, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0038);
      step();
      set_instr(OP_ADD, 4'd6, 4'd5, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 16'h0039);
`ifdef PIPE_FWD_EN
      @(negedge clk);
      exp_c = ctl(0,1,0,3,0,0,0,0,0); n_checks++;
      if (obs !== exp_c) begin n_fail++; $display("FAIL load_stall: got %b want %b", obs, exp_c); end
      step();
      @(negedge clk);
      exp_c = ctl(1,0,0,0,2,0,0,0,0); n_checks++;
      if (obs !== exp_c) begin n_fail++; $display("FAIL load_fwd_m: got %b want %b", obs, exp_c); end
      step();
`else
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         exp_c = ctl(0,1,0,3,0,0,0,0,0); n_checks++;
         if (obs !== exp_c) begin n_fail++; $display("FAIL load_stall_%0d: got %b want %b", i, obs, exp_c); end
         step();
      end
      @(negedge clk);
      exp_c = ctl(1,0,0,0,0,0,0,0,0); n_checks++;
      if (obs !== exp_c) begin n_fail++; $display("FAIL load_issue: got %b want %b", obs, exp_c); end
      step();
`endif
      idle_cycles(2);
   endtask

   task automatic test_branch();
      set_instr(OP_JUMP, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0050);
      @(negedge clk);
      exp_c = ctl(1,0,1,1,0,0,0,0,0); n_checks++;
      if (obs !== exp_c) begin n_fail++; $display("FAIL jump: got %b want %b", obs, exp_c); end
      step();
      idle_cycles(1);
      set_instr(OP_JUMPF, 4'd0, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b1, 16'h0060);
      @(negedge clk);
      exp_c = ctl(1,0,0,0,0,0,0,0,0); n_checks++;
      if (obs !== exp_c) begin n_fail++; $display("FAIL jumpf_not_taken: got %b want %b", obs, exp_c); end
      step();
      set_instr(OP_JUMPF, 4'd0, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b1, 16'h0061);
      bus_if.br_false = 1'b1;
      @(negedge clk);
      exp_c = ctl(1,0,1,1,0,0,0,0,0); n_checks++;
      if (obs !== exp_c) begin n_fail++; $display("FAIL jumpf_taken: got %b want %b", obs, exp_c); end
      step();
      idle_cycles(1);
      set_instr(OP_ADD, 4'd3, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0070);
      step();
      set_instr(OP_JUMPF, 4'd0, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b1, 16'h0071);
      bus_if.br_false = 1'b1;
`ifdef PIPE_FWD_EN
      @(negedge clk);
      exp_c = ctl(1,0,1,1,0,0,1,0,0); n_checks++;
      if (obs !== exp_c) begin n_fail++; $display("FAIL jumpf_fwd_d: got %b want %b", obs, exp_c); end
      step();
`else
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         exp_c = ctl(0,1,0,3,0,0,0,0,0); n_checks++;
         if (obs !== exp_c) begin n_fail++; $display("FAIL jumpf_stall_%0d: got %b want %b", i, obs, exp_c); end
         step();
      end
      @(negedge clk);
      exp_c = ctl(1,0,1,1,0,0,0,0,0); n_checks++;
      if (obs !== exp_c) begin n_fail++; $display("FAIL jumpf_resolve_late: got %b want %b", obs, exp_c); end
      step();
`endif
      idle_cycles(2);
   endtask

   task automatic test_call_ret();
      set_instr(OP_CALL, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0040);
      @(negedge clk);
      exp_c = ctl(1,0,1,1,0,0,0,0,0); n_checks++;
      if (obs !== exp_c) begin n_fail++; $display("FAIL call: got %b want %b", obs, exp_c); end
      step();
      set_idle();
      @(negedge clk);
      n_checks++;
      if (bus_if.ret_addr !== 16'h0041) begin n_fail++; $display("FAIL call_tos: got %h want 0041", bus_if.ret_addr); end
      step();
      set_instr(OP_RET, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0090);
      @(negedge clk);
      exp_c = ctl(1,0,1,2,0,0,0,0,0); n_checks++;
      if (obs !== exp_c) begin n_fail++; $display("FAIL ret: got %b want %b", obs, exp_c); end
      n_checks++;
      if (bus_if.ret_addr !== 16'h0041) begin n_fail++; $display("FAIL ret_addr: got %h want 0041", bus_if.ret_addr); end
      step();
      set_idle();
      @(negedge clk);
      n_checks++;
      if (bus_if.ret_addr !== 16'h0000) begin n_fail++; $display("FAIL ret_empty_after: got %h want 0000", bus_if.ret_addr); end
      step();
   endtask

   task automatic test_call_overflow();
      exp_q.delete();
      exp_ovf = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         set_instr(OP_CALL, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 16'(k * 256));
         @(negedge clk);
         exp_c = ctl(1,0,1,1,0,0,0,0,int'(exp_ovf)); n_checks++;
         if (obs !== exp_c) begin n_fail++; $display("FAIL ovf_call_%0d: got %b want %b", k, obs, exp_c); end
         if (exp_q.size() == 4) begin
            void'(exp_q.pop_front());
            exp_ovf = 1'b1;
         end
         exp_q.push_back(16'(k * 256 + 1));
         step();
         set_idle();
         @(negedge clk);
         exp_c = ctl(0,0,0,0,0,0,0,0,int'(exp_ovf)); n_checks++;
         if (obs !== exp_c) begin n_fail++; $display("FAIL ovf_flag_%0d: got %b want %b", k, obs, exp_c); end
         n_checks++;
         if (bus_if.ret_addr !== exp_q[$]) begin n_fail++; $display("FAIL ovf_tos_%0d: got %h want %h", k, bus_if.ret_addr, exp_q[$]); end
         step();
      end
      for (int k = 1; k <= 5; k++) begin
         set_instr(OP_RET, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0900);
         exp_ra = (exp_q.size() != 0) ? exp_q[$] : 16'h0000;
         @(negedge clk);
         exp_c = ctl(1,0,1,2,0,0,0,0,1); n_checks++;
         if (obs !== exp_c) begin n_fail++; $display("FAIL ovf_ret_%0d: got %b want %b", k, obs, exp_c); end
         n_checks++;
         if (bus_if.ret_addr !== exp_ra) begin n_fail++; $display("FAIL ovf_ret_addr_%0d: got %h want %h", k, bus_if.ret_addr, exp_ra); end
         if (exp_q.size() != 0) void'(exp_q.pop_back());
         step();
         idle_cycles(1);
      end
   endtask

   task automatic test_reset_clears_ovf();
      set_idle();
      @(negedge clk);
      reset = 1'b0;
      #1;
      exp_c = ctl(0,0,0,0,0,0,0,0,0); n_checks++;
      if (obs !== exp_c) begin n_fail++; $display("FAIL reset_clears_ovf: got %b want %b", obs, exp_c); end
      step();
      reset = 1'b1;
      step();
   endtask

   task automatic test_trap_drain();
      set_instr(OP_TRAP, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0A00);
      @(negedge clk);
      exp_c = ctl(1,0,0,0,0,0,0,0,0); n_checks++;
      if (obs !== exp_c) begin n_fail++; $display("FAIL trap_issue: got %b want %b", obs, exp_c); end
      step();
      set_instr(OP_ADD, 4'd1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0A01);
      for (int i = 1; i <= 2; i++) begin
         @(negedge clk);
         exp_c = ctl(0,1,0,3,0,0,0,0,0); n_checks++;
         if (obs !== exp_c) begin n_fail++; $display("FAIL trap_drain_n%0d: got %b want %b", i, obs, exp_c); end
         step();
      end
      for (int i = 3; i <= 4; i++) begin
         @(negedge clk);
         exp_c = ctl(0,1,0,3,0,0,0,1,0); n_checks++;
         if (obs !== exp_c) begin n_fail++; $display("FAIL trap_halt_n%0d: got %b want %b", i, obs, exp_c); end
         n_checks++;
         if (bus_if.dbg_state !== 2'd2) begin n_fail++; $display("FAIL trap_state_n%0d: got %0d want 2", i, bus_if.dbg_state); end
         step();
      end
      set_idle();
      @(negedge clk);
      reset = 1'b0;
      #1;
      exp_c = ctl(0,0,0,0,0,0,0,0,0); n_checks++;
      if (obs !== exp_c) begin n_fail++; $display("FAIL halt_reset: got %b want %b", obs, exp_c); end
      step();
      reset = 1'b1;
      step();
   endtask

   task automatic test_reset_in_drain();
      set_instr(OP_CALL, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0700);
      step();
      idle_cycles(1);
      set_instr(OP_ADD, 4'd2, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0800);
      step();
      set_instr(OP_TRAP, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0801);
      step();
      set_idle();
      @(negedge clk);
      exp_c = ctl(0,1,0,3,0,0,0,0,0); n_checks++;
      if (obs !== exp_c) begin n_fail++; $display("FAIL rid_draining: got %b want %b", obs, exp_c); end
      #2;
      reset = 1'b0;
      #1;
      exp_c = ctl(0,0,0,0,0,0,0,0,0); n_checks++;
      if (obs !== exp_c) begin n_fail++; $display("FAIL rid_async_ctl: got %b want %b", obs, exp_c); end
      n_checks++;
      if (bus_if.dbg_state !== 2'd0) begin n_fail++; $display("FAIL rid_state: got %0d want 0", bus_if.dbg_state); end
      n_checks++;
      if (bus_if.ret_addr !== 16'h0000) begin n_fail++; $display("FAIL rid_stack: got %h want 0000", bus_if.ret_addr); end
      step();
      reset = 1'b1;
      set_instr(OP_ADD, 4'd4, 4'd2, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0000);
      @(negedge clk);
      exp_c = ctl(1,0,0,0,0,0,0,0,0); n_checks++;
      if (obs !== exp_c) begin n_fail++; $display("FAIL rid_add_after: got %b want %b", obs, exp_c); end
      step();
      idle_cycles(2);
   endtask

   initial begin
      set_idle();
      test_reset();
      test_alu_hazard();
      test_m_hazard();
      test_r0_source();
      test_load_use();
      test_branch();
      test_call_ret();
      test_call_overflow();
      test_reset_clears_ovf();
      test_trap_drain();
      test_reset_in_drain();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/pipe_sequencer.md
# pipe_sequencer

Issue/hazard controller for the 4-stage processor pipeline. It sits between the decoder and stage 1. Each cycle it decides whether the decoded instruction issues, stalls or is flushed, and it selects the next PC. It also owns the return-address call stack and the trap/halt drain sequence. It holds a scoreboard of destination registers in flight, and it drives the operand-forwarding selects consumed by the stage-1 operand muxes.

## Interface
- DEPTH, 4, call-stack entries (power of 2, ≥2)
- clk  in  1  clock, all state updates on posedge
- reset  in  1  asynchronous, active-low
- dec_valid  in  1  decoder holds a valid instruction
- dec_op  in  5  unique pipeline op (codebase 5-bit encoding; nop = 5'b11111)
- dec_rd  in  4  destination register; 0 = no write
- dec_rs, dec_rt, dec_rdsrc  in  4 each  source register fields S, T, D
- dec_use_s, dec_use_t, dec_use_d  in  1 each  source field actually read
- dec_pc  in  16  PC of decoded instruction
- br_false  in  1  forwarded D value of a jumpf is zero
- issue  out  1  instruction enters stage 1 this cycle
- stall  out  1  hold PC and decoder register
- flush  out  1  squash the instruction behind a taken control transfer
- pc_sel  out  2  0 = pc+1, 1 = jump target (immediate path), 2 = ret_addr, 3 = hold
- ret_addr  out  16  top of call stack
- fwd_s, fwd_t, fwd_d  out  2 each  0 = regfile, 1 = ALU result (X), 2 = stage-2 latch (M)
- halt  out  1  sticky, processor stopped
- cs_ovf  out  1  sticky, call stack overflowed

## Operation
- The scoreboard has two slots, X (stage 2) and M (writeback pending). Each slot holds {valid, rd, is_load}.
- On every unstalled clock, M<=X. X<=issued instruction, or empty when no instruction issues.
- A source hazard exists when a used source is nonzero and equals the rd of a valid X or M slot.
- Forward select priority: X over M.
- issue = dec_valid & ~stall & state==RUN.
- Write ops: the decoder presents dec_rd=0 for non-writing ops. The sequencer trusts dec_rd.
- Control ops are resolved at issue:
  - jump: pc_sel=1, flush=1.
  - jumpf: taken only if br_false; then pc_sel=1, flush=1. It uses D as a source.
  - call: push dec_pc+1, pc_sel=1, flush=1.
  - ret: pop, pc_sel=2, flush=1. ret_addr shows the top-of-stack before the pop.
- Call stack behaviour:
  - Push when full: discard the oldest entry and set cs_ovf.
  - Pop when empty: ret_addr=0. The stack stays empty.
- Trap state machine:
  - RUN: trap issues, then go to DRAIN.
  - DRAIN: stall=1, pc_sel=3. Go to HALT when X and M are both empty, which is exactly 2 cycles after the trap issues.
  - HALT: halt=1 until reset. All outputs stay frozen.
- Stall has priority over control resolution. A branch with a pending hazard neither resolves nor flushes until its stall clears.
- flush and stall are never asserted together.

## Timing
- Reset values: issue=0, stall=0, flush=0, pc_sel=0, ret_addr=0, fwd_*=0, halt=0, cs_ovf=0. Scoreboard and call stack are empty; state=RUN.
- Reset asserted mid-operation clears everything immediately (asynchronously), including a DRAIN in progress.
- stall, flush, pc_sel and fwd_* are combinational from the dec_* inputs and registered state, valid in the same cycle. Scoreboard and stack update on posedge.
- A control transfer costs 1 bubble: the flushed slot enters X as empty.
- Stall lengths: see Configuration. A stall inserts an empty slot into X per stalled cycle and re-evaluates every cycle.
- A push and pop in the same cycle cannot occur (one instruction per cycle).

## Configuration
- PIPE_FWD_EN defined:
  - Hazards on X (non-load) and M are forwarded via fwd_* with no stall.
  - A load in X that is matched by a source stalls 1 cycle, then forwards from M (fwd=2).
- PIPE_FWD_EN undefined:
  - fwd_* are tied to 0.
  - Any hazard stalls until the producer leaves M, i.e. up to 2 cycles.

## Test plan
- add r1,r2,r3 then add r4,r1,r1:
  - FWD_EN: no stall, fwd_s=fwd_t=1.
  - Without FWD_EN: stall=1 for 2 cycles, then issue with fwd=0.
- load r5 then add r6,r5,r0 with FWD_EN: stall=1 for exactly 1 cycle, then issue with fwd_s=2.
- call at dec_pc=16'h0040 then ret:
  - The call gives pc_sel=1, flush=1.
  - The ret gives ret_addr=16'h0041, pc_sel=2, flush=1, and the stack is empty afterwards.
- Five nested calls with DEPTH=4: cs_ovf=1. Four rets return the 2nd..5th pushed addresses in LIFO order; a fifth ret gives ret_addr=0.
- trap issued at cycle N: stall=1 at N+1 and N+2, halt=1 from N+3. A dec_valid add presented after the trap never issues.
- Drive reset low during DRAIN: halt=0, scoreboard empty, stack empty, state=RUN, and the next add issues normally.
